// File: rtl/mio_bus_fabric_if.sv
// CPU-side and slave-side bus bundle for the MIO fabric.
// The master modport is the fabric's view; slave is the surrounding CPU/slave view.
interface mio_bus_fabric_if #(
  parameter int N_SLAVES = 7,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32
);
  logic                         cpu_req;
  logic                         cpu_we;
  logic [ADDR_W-1:0]            cpu_addr;
  logic [DATA_W-1:0]            cpu_wdata;
  logic                         cpu_ready;
  logic                         cpu_err;
  logic [DATA_W-1:0]            cpu_rdata;
  logic [N_SLAVES-1:0]          s_sel;
  logic                         s_we;
  logic [ADDR_W-1:0]            s_addr;
  logic [DATA_W-1:0]            s_wdata;
  logic [N_SLAVES*DATA_W-1:0]   s_rdata;
  logic [N_SLAVES-1:0]          s_ack;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, s_rdata, s_ack,
    output cpu_ready, cpu_err, cpu_rdata, s_sel, s_we, s_addr, s_wdata
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, s_rdata, s_ack,
    input  cpu_ready, cpu_err, cpu_rdata, s_sel, s_we, s_addr, s_wdata
  );
endinterface

// File: rtl/mio_bus_fabric.sv
// Registered MIO decoder: decodes CPU accesses onto one-hot slave selects, holds the
// transaction until ack/timeout, and returns a one-cycle registered response.
module mio_bus_fabric #(
  parameter int                    N_SLAVES   = 7,
  parameter int                    DATA_W     = 32,
  parameter int                    ADDR_W     = 32,
  parameter int                    TAG_W      = 4,
  parameter logic [N_SLAVES*TAG_W-1:0] SLAVE_TAGS = 28'hFEDC210,
  parameter int                    TIMEOUT    = 15,
  parameter int                    TO_W       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mio_bus_fabric_if.master  bus,
  output logic [15:0]       err_cnt
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state;
  logic [TO_W-1:0]     timer;
  logic [TAG_W-1:0]    tag;
  logic [N_SLAVES-1:0] match;
  logic [N_SLAVES-1:0] sel_nxt;
  logic                hit;
  logic                sel_ack;
  logic [DATA_W-1:0]   sel_rdata;

  assign tag = bus.cpu_addr[ADDR_W-1 -: TAG_W];

  for (genvar i = 0; i < N_SLAVES; i++) begin : g_match
    assign match[i] = (tag == SLAVE_TAGS[TAG_W*i +: TAG_W]);
  end

  assign hit = |match;

  // Walk downwards so the lowest matching index wins when tags alias.
  always_comb begin
    sel_nxt = '0;
    for (int i = N_SLAVES-1; i >= 0; i--)
      if (match[i]) sel_nxt = N_SLAVES'(1) << i;
  end

  // Only the selected slave's ack and data count; strays are masked off.
  assign sel_ack = |(bus.s_ack & bus.s_sel);

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++)
      if (bus.s_sel[i]) sel_rdata = bus.s_rdata[DATA_W*i +: DATA_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      timer         <= '0;
      bus.s_sel     <= '0;
      bus.s_we      <= 1'b0;
      bus.s_addr    <= '0;
      bus.s_wdata   <= '0;
      bus.cpu_ready <= 1'b0;
      bus.cpu_err   <= 1'b0;
      bus.cpu_rdata <= '0;
      err_cnt       <= '0;
    end else begin
      case (state)
        IDLE: if (bus.cpu_req) begin
          bus.s_addr  <= bus.cpu_addr;
          bus.s_wdata <= bus.cpu_wdata;
          timer       <= '0;
          if (bus.cpu_addr[1:0] != 2'b00 || !hit) begin
            bus.cpu_ready <= 1'b1;
            bus.cpu_err   <= 1'b1;
            bus.cpu_rdata <= '0;
            state         <= RESP;
          end else begin
            bus.s_sel <= sel_nxt;
            bus.s_we  <= bus.cpu_we;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (sel_ack) begin
            bus.cpu_ready <= 1'b1;
            bus.cpu_err   <= 1'b0;
            bus.cpu_rdata <= bus.s_we ? '0 : sel_rdata;
            bus.s_sel     <= '0;
            bus.s_we      <= 1'b0;
            state         <= RESP;
          end else if (timer == TO_W'(TIMEOUT-1)) begin
            bus.cpu_ready <= 1'b1;
            bus.cpu_err   <= 1'b1;
            bus.cpu_rdata <= '0;
            bus.s_sel     <= '0;
            bus.s_we      <= 1'b0;
            state         <= RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RESP: begin
          bus.cpu_ready <= 1'b0;
          bus.cpu_err   <= 1'b0;
          if (bus.cpu_err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
